// File: rtl/sram_req_arbiter_if.sv
// Bundle of the two sram-like master channels (inst, data) and the shared slave channel.
// The arbiter binds to "slave"; the environment (CPU masters and memory model) binds to "master".
interface sram_req_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-master sram-like arbiter: data-priority grant with inst anti-starvation, and an
// in-order ID FIFO that routes the shared slave's responses back to the requesting master.
module sram_req_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  resetn,
  sram_req_arbiter_if.slave    bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_e;

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [STV_W-1:0] starve_q;
  src_e             id_fifo [DEPTH];

  logic full, grant_data, grant_inst, push, pop;
  src_e head_id;

  // The starve limit overrides the default data priority only while inst is waiting.
  assign grant_data = bus.data_req & ~(bus.inst_req & (starve_q == STARVE_LIM));
  assign grant_inst = bus.inst_req & ~grant_data;
  assign full       = (count_q == FULL_CNT);

  assign bus.mem_req   = (bus.inst_req | bus.data_req) & ~full & ~resetn;
  assign bus.mem_wr    = grant_inst ? 1'b0     : bus.data_wr;
  assign bus.mem_size  = grant_inst ? 2'd2     : bus.data_size;
  assign bus.mem_wstrb = grant_inst ? 4'h0     : bus.data_wstrb;
  assign bus.mem_addr  = grant_inst ? bus.inst_addr : bus.data_addr;
  assign bus.mem_wdata = grant_inst ? 32'h0    : bus.data_wdata;

  assign push = bus.mem_req & bus.mem_addr_ok;
  assign bus.inst_addr_ok = push & grant_inst;
  assign bus.data_addr_ok = push & grant_data;

  // Responses with nothing outstanding are dropped silently.
  assign pop     = bus.mem_data_ok & (count_q != '0) & ~resetn;
  assign head_id = id_fifo[rd_ptr_q];
  assign bus.inst_data_ok = pop & (head_id == SRC_INST);
  assign bus.data_data_ok = pop & (head_id == SRC_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  // NOTE: the ID storage has no reset; an entry is only read while count_q marks it valid.
  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr_q] <= grant_data ? SRC_DATA : SRC_INST;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (!bus.inst_req || bus.inst_addr_ok)
        starve_q <= '0;
      else if (bus.data_addr_ok && starve_q != STARVE_LIM)
        starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: a stimulus process predicts each cycle from a queue
// model of outstanding requests; a separate monitor compares what the DUT presents.
module tb_sram_req_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  sram_req_arbiter_if bus ();

  sram_req_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    bit        mem_req, iaok, daok, resp, wr;
    bit [1:0]  size;
    bit [3:0]  wstrb;
    bit [31:0] addr, wdata;
  } cyc_t;

  typedef struct {
    bit        src;
    bit [31:0] rdata;
  } resp_t;

  cyc_t  cyc_q[$];
  resp_t resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: IDs awaiting a response, and length of the current data-over-inst streak.
  bit outstanding[$];
  int streak = 0;

  // Master-side request state (held until accepted).
  bit        i_pend = 0, d_pend = 0;
  bit [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  bit        d_wr = 0;
  bit [1:0]  d_size = '0;
  bit [3:0]  d_wstrb = '0;
  bit        g_inst_acc, g_data_acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit aok, input bit dok, input bit [31:0] rd);
    cyc_t  c;
    resp_t r;
    bit    pick_data;
    @(negedge clk);
    resetn          = rst;
    bus.inst_req    = i_pend;
    bus.inst_addr   = i_addr;
    bus.data_req    = d_pend;
    bus.data_wr     = d_wr;
    bus.data_size   = d_size;
    bus.data_wstrb  = d_wstrb;
    bus.data_addr   = d_addr;
    bus.data_wdata  = d_wdata;
    bus.mem_addr_ok = aok;
    bus.mem_data_ok = dok;
    bus.mem_rdata   = rd;
    #1;
    c = '{default: 0};
    g_inst_acc = 0;
    g_data_acc = 0;
    if (rst) begin
      outstanding.delete();
      streak = 0;
    end else begin
      c.mem_req = (i_pend || d_pend) && (outstanding.size() < DEPTH);
      pick_data = d_pend && !(i_pend && streak >= STARVE_MAX);
      c.iaok    = c.mem_req && aok && !pick_data;
      c.daok    = c.mem_req && aok && pick_data;
      if (pick_data) begin
        c.wr = d_wr; c.size = d_size; c.wstrb = d_wstrb; c.addr = d_addr; c.wdata = d_wdata;
      end else begin
        c.wr = 0; c.size = 2; c.wstrb = 0; c.addr = i_addr; c.wdata = 0;
      end
      c.resp = dok && (outstanding.size() > 0);
      if (c.resp) begin
        r.src   = outstanding.pop_front();
        r.rdata = rd;
        resp_q.push_back(r);
      end
      if (c.iaok) outstanding.push_back(1'b0);
      if (c.daok) outstanding.push_back(1'b1);
      if (!i_pend || c.iaok) streak = 0;
      else if (c.daok && streak < STARVE_MAX) streak++;
      g_inst_acc = c.iaok;
      g_data_acc = c.daok;
      if (c.iaok) i_pend = 0;
      if (c.daok) d_pend = 0;
    end
    cyc_q.push_back(c);
  endtask

  // Monitor: runs after the stimulus has published the cycle's prediction.
  initial begin
    cyc_t  c;
    resp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("mem_req", bus.mem_req, c.mem_req);
        check("inst_addr_ok", bus.inst_addr_ok, c.iaok);
        check("data_addr_ok", bus.data_addr_ok, c.daok);
        check("any_data_ok", bus.inst_data_ok | bus.data_data_ok, c.resp);
        if (c.mem_req) begin
          check("mem_addr", bus.mem_addr, c.addr);
          check("mem_fields", {bus.mem_wr, bus.mem_size, bus.mem_wstrb}, {c.wr, c.size, c.wstrb});
          check("mem_wdata", bus.mem_wdata, c.wdata);
        end
      end
      if (bus.inst_data_ok | bus.data_data_ok) begin
        if (resp_q.size() == 0) begin
          check("unexpected_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
        end else begin
          r = resp_q.pop_front();
          check("resp_route", {bus.inst_data_ok, bus.data_data_ok}, r.src ? 2'b01 : 2'b10);
          check("resp_rdata", r.src ? bus.data_rdata : bus.inst_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    bus.inst_req = 0; bus.inst_addr = '0; bus.data_req = 0; bus.data_wr = 0;
    bus.data_size = '0; bus.data_wstrb = '0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;

    // Reset: requests and a stray response must be suppressed.
    i_pend = 1; d_pend = 1;
    cycle(1, 1, 1, 32'hdead_beef);
    #2 check("rst_outputs", {bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok,
                             bus.inst_data_ok, bus.data_data_ok}, 5'b0);
    i_pend = 0; d_pend = 0;
    cycle(1, 0, 0, '0);

    // Single fetch with one-cycle response.
    i_pend = 1; i_addr = 32'h1c00_0000;
    cycle(0, 1, 0, '0);
    #2 check("fetch_addr_ok", bus.inst_addr_ok, 1);
    check("fetch_mem_addr", bus.mem_addr, 32'h1c00_0000);
    cycle(0, 0, 1, 32'h0280_0000);
    #2 check("fetch_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b10);
    check("fetch_rdata", bus.inst_rdata, 32'h0280_0000);

    // Both masters always requesting: D,D,D,D,I repeating.
    for (int k = 0; k < 20; k++) begin
      i_pend = 1; d_pend = 1; i_addr = 32'h1000 + k * 4; d_addr = 32'h2000 + k * 4;
      d_wr = k[0]; d_size = 2'(k % 3); d_wstrb = 4'(k); d_wdata = $urandom;
      cycle(0, 1, outstanding.size() > 0, $urandom);
      check("starve_order", g_inst_acc, (k % 5 == 4));
    end
    i_pend = 0; d_pend = 0;
    cycle(0, 0, 1, $urandom);

    // Fill to DEPTH, then a single response re-opens the port one cycle later.
    for (int k = 0; k < 3; k++) begin
      d_pend = 1; d_addr = 32'h3000 + k * 4;
      cycle(0, 1, 0, '0);
      #2 check("fill_mem_req", bus.mem_req, (k < 2));
    end
    cycle(0, 1, 1, 32'h55);
    #2 check("full_pop_mem_req", bus.mem_req, 0);
    cycle(0, 1, 0, '0);
    #2 check("reopen_mem_req", bus.mem_req, 1);
    d_pend = 0;
    cycle(0, 0, 1, 32'h66);
    cycle(0, 0, 1, 32'h77);

    // Accept I then D; responses routed in order.
    i_pend = 1; i_addr = 32'h4000;
    cycle(0, 1, 0, '0);
    d_pend = 1; d_addr = 32'h5000;
    cycle(0, 1, 0, '0);
    cycle(0, 0, 1, 32'h0000_000a);
    #2 check("order_first", {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}, {2'b10, 32'ha});
    cycle(0, 0, 1, 32'h0000_000b);
    #2 check("order_second", {bus.inst_data_ok, bus.data_data_ok, bus.data_rdata}, {2'b01, 32'hb});

    // Stray response, then reset with one outstanding.
    cycle(0, 0, 1, 32'h99);
    #2 check("stray_no_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    i_pend = 1; i_addr = 32'h6000;
    cycle(0, 1, 0, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 1, 32'h88);
    #2 check("post_rst_no_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = $urandom & 32'hffff_fffc;
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1; d_addr = $urandom; d_wr = 1'($urandom);
        d_size = 2'($urandom_range(0, 2)); d_wstrb = 4'($urandom); d_wdata = $urandom;
      end
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            (outstanding.size() > 0) ? 1'($urandom) : ($urandom_range(0, 19) == 0), $urandom);
    end
    i_pend = 0; d_pend = 0;
    cycle(0, 0, 1, $urandom);
    cycle(0, 0, 1, $urandom);

    @(negedge clk);
    #3;
    check("cyc_q_drained", cyc_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: maximum outstanding accepted requests awaiting data_ok (power of two, 2..8).
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants tolerated while inst_req is pending.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-high reset (resetn==1 <-> reset).
REQ-005 inst_req  in  1  fetch request, sram-like, read-only.
REQ-006 inst_addr  in  32  fetch address.
REQ-007 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-008 inst_data_ok  out  1  fetch data returned this cycle.
REQ-009 inst_rdata  out  32  fetch data.
REQ-010 data_req  in  1  load/store request.
REQ-011 data_wr  in  1  1 = store.
REQ-012 data_size  in  2  0/1/2 = byte/half/word.
REQ-013 data_wstrb  in  4  store byte enables.
REQ-014 data_addr  in  32  load/store address.
REQ-015 data_wdata  in  32  store data.
REQ-016 data_addr_ok  out  1  load/store accepted this cycle.
REQ-017 data_data_ok  out  1  load data returned / store completed.
REQ-018 data_rdata  out  32  load data.
REQ-019 mem_req  out  1  request to shared sram-like slave.
REQ-020 mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  granted master's fields, muxed.
REQ-021 mem_addr_ok  in  1  slave accepted request.
REQ-022 mem_data_ok  in  1  slave response, strictly in request order.
REQ-023 mem_rdata  in  32  slave response data.

Function
REQ-024 Grant is combinational per cycle: data wins when both request, except when the starve counter equals STARVE_MAX, in which case inst wins.
REQ-025 Inst grant drives mem_wr=0, mem_size=2, mem_wstrb=0, and mem_wdata=0.
REQ-026 mem_req = (inst_req | data_req) & ~full, where full means outstanding count == DEPTH.
REQ-027 x_addr_ok = mem_addr_ok & mem_req & grant_x; at most one is high per cycle.
REQ-028 On accept (mem_req & mem_addr_ok), the granted source ID (0=inst, 1=data) is pushed into a DEPTH-entry ID FIFO with count 0..DEPTH.
REQ-029 On mem_data_ok with count>0, the head ID is popped; inst_data_ok or data_data_ok pulses the same cycle (zero latency); inst_rdata = data_rdata = mem_rdata unconditionally.
REQ-030 Simultaneous push and pop: count is unchanged, both pointers advance, and the head ID is used for routing before the push is visible.
REQ-031 A push is impossible when full (REQ-026); a pop completing in the same cycle does not re-enable mem_req until the next cycle.
REQ-032 mem_data_ok with count==0 is a protocol error: it is ignored, no master data_ok is issued, and state is unchanged.
REQ-033 Pointers wrap modulo DEPTH.
REQ-034 Starve counter: +1 on each data accept while inst_req=1; cleared on any inst accept or when inst_req=0; saturates at STARVE_MAX.
REQ-035 Requests are not cancellable; a master holding req with changing fields is a master error and is unspecified.

Reset
REQ-036 While resetn=1: count=0, pointers=0, starve counter=0; mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, and data_data_ok are forced to 0.
REQ-037 Reset asserted with requests outstanding discards all tracked IDs; responses arriving after release fall under REQ-032.

Verification
REQ-038 Only inst_req=1, addr 0x1c000000, mem_addr_ok=1, then mem_data_ok=1 with rdata 0x02800000 one cycle later -> inst_addr_ok in cycle 0, inst_data_ok with inst_rdata=0x02800000 in cycle 1, and data_data_ok=0.
REQ-039 Both req=1 every cycle, mem_addr_ok=1, responses returned promptly -> grant order D,D,D,D,I repeating (STARVE_MAX=4).
REQ-040 DEPTH=2, mem_addr_ok=1, no mem_data_ok -> two accepts, then mem_req=0; one mem_data_ok -> mem_req=1 the following cycle.
REQ-041 Accept I then D, return two responses 0xA then 0xB -> inst_data_ok with 0xA first, then data_data_ok with 0xB.
REQ-042 mem_data_ok with count=0, then resetn pulsed with one outstanding -> no data_ok pulses, and count=0 after reset.
